// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite N-to-1 interconnect: response
// codes, per-path FSM states and the grant index width helper.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/axil_rr_arbiter.sv
// Request arbiter for one interconnect path. Round-robin by default; defining
// AXIL_NTO1_FIXED_PRIO_EN switches to fixed priority (lowest index wins).
module axil_rr_arbiter
  import axil_pkg::*;
#(
  parameter  int NUM_M = 4,
  localparam int IDX_W = clog2(NUM_M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] req,
  input  logic             advance,
  input  logic [IDX_W-1:0] adv_idx,
  output logic [IDX_W-1:0] grant,
  output logic             any_req
);

  logic found;

  assign any_req = |req;

`ifdef AXIL_NTO1_FIXED_PRIO_EN
  logic unused_rr_inputs;
  assign unused_rr_inputs = ^{clk, rst, advance, adv_idx};

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (req[i] && !found) begin
        grant = IDX_W'(i);
        found = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr;
  int               idx;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst)          ptr <= '0;
    else if (advance) ptr <= (adv_idx == IDX_W'(NUM_M - 1)) ? '0 : adv_idx + IDX_W'(1);
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loop can leave a value held (no latch).
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_M; i++) begin
      idx = (int'(ptr) + i) % NUM_M;
      if (req[idx] && !found) begin
        grant = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/axil_nto1_interconnect.sv
// AXI4-Lite N-master to 1-slave interconnect with independent write and read
// arbitration; AXIL_NTO1_FIXED_PRIO_EN selects fixed-priority arbitration.
module axil_nto1_interconnect
  import axil_pkg::*;
#(
  parameter  int NUM_M  = 4,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int IDX_W  = clog2(NUM_M)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [NUM_M*ADDR_W-1:0]  m_awaddr,
  input  logic [NUM_M*3-1:0]       m_awprot,
  input  logic [NUM_M-1:0]         m_awvalid,
  output logic [NUM_M-1:0]         m_awready,
  input  logic [NUM_M*DATA_W-1:0]  m_wdata,
  input  logic [NUM_M*STRB_W-1:0]  m_wstrb,
  input  logic [NUM_M-1:0]         m_wvalid,
  output logic [NUM_M-1:0]         m_wready,
  output logic [1:0]               m_bresp,
  output logic [NUM_M-1:0]         m_bvalid,
  input  logic [NUM_M-1:0]         m_bready,
  input  logic [NUM_M*ADDR_W-1:0]  m_araddr,
  input  logic [NUM_M*3-1:0]       m_arprot,
  input  logic [NUM_M-1:0]         m_arvalid,
  output logic [NUM_M-1:0]         m_arready,
  output logic [DATA_W-1:0]        m_rdata,
  output logic [1:0]               m_rresp,
  output logic [NUM_M-1:0]         m_rvalid,
  input  logic [NUM_M-1:0]         m_rready,
  output logic [ADDR_W-1:0]        s_awaddr,
  output logic [2:0]               s_awprot,
  output logic                     s_awvalid,
  input  logic                     s_awready,
  output logic [DATA_W-1:0]        s_wdata,
  output logic [STRB_W-1:0]        s_wstrb,
  output logic                     s_wvalid,
  input  logic                     s_wready,
  input  logic [1:0]               s_bresp,
  input  logic                     s_bvalid,
  output logic                     s_bready,
  output logic [ADDR_W-1:0]        s_araddr,
  output logic [2:0]               s_arprot,
  output logic                     s_arvalid,
  input  logic                     s_arready,
  input  logic [DATA_W-1:0]        s_rdata,
  input  logic [1:0]               s_rresp,
  input  logic                     s_rvalid,
  output logic                     s_rready
);

  w_state_t         w_state, w_next;
  r_state_t         r_state, r_next;
  logic [IDX_W-1:0] gw, gr, gw_arb, gr_arb;
  logic             w_any, r_any;
  logic             aw_done, w_done;
  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign m_bresp = s_bresp;
  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;

  axil_rr_arbiter #(.NUM_M(NUM_M)) u_w_arb (
    .clk(aclk), .rst(areset), .req(m_awvalid), .advance(b_hs),
    .adv_idx(gw), .grant(gw_arb), .any_req(w_any)
  );

  axil_rr_arbiter #(.NUM_M(NUM_M)) u_r_arb (
    .clk(aclk), .rst(areset), .req(m_arvalid), .advance(r_hs),
    .adv_idx(gr), .grant(gr_arb), .any_req(r_any)
  );

  // Write path: the slave only ever sees the granted master's slice; outputs
  // are zero outside W_ADDR so a reset drops slave valids on the same edge.
  always_comb begin
    w_next    = w_state;
    s_awaddr  = '0;
    s_awprot  = '0;
    s_awvalid = 1'b0;
    m_awready = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wvalid  = 1'b0;
    m_wready  = '0;
    m_bvalid  = '0;
    s_bready  = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    b_hs      = 1'b0;
    case (w_state)
      W_IDLE: if (w_any) w_next = W_ADDR;
      W_ADDR: begin
        s_awaddr      = m_awaddr[int'(gw)*ADDR_W +: ADDR_W];
        s_awprot      = m_awprot[int'(gw)*3 +: 3];
        s_awvalid     = m_awvalid[gw] & ~aw_done;
        m_awready[gw] = s_awready & ~aw_done;
        s_wdata       = m_wdata[int'(gw)*DATA_W +: DATA_W];
        s_wstrb       = m_wstrb[int'(gw)*STRB_W +: STRB_W];
        s_wvalid      = m_wvalid[gw] & ~w_done;
        m_wready[gw]  = s_wready & ~w_done;
        aw_hs         = s_awvalid & s_awready;
        w_hs          = s_wvalid & s_wready;
        if ((aw_done | aw_hs) && (w_done | w_hs)) w_next = W_RESP;
      end
      W_RESP: begin
        m_bvalid[gw] = s_bvalid;
        s_bready     = m_bready[gw];
        b_hs         = s_bvalid & m_bready[gw];
        if (b_hs) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next    = r_state;
    s_araddr  = '0;
    s_arprot  = '0;
    s_arvalid = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    s_rready  = 1'b0;
    ar_hs     = 1'b0;
    r_hs      = 1'b0;
    case (r_state)
      R_IDLE: if (r_any) r_next = R_ADDR;
      R_ADDR: begin
        s_araddr      = m_araddr[int'(gr)*ADDR_W +: ADDR_W];
        s_arprot      = m_arprot[int'(gr)*3 +: 3];
        s_arvalid     = m_arvalid[gr];
        m_arready[gr] = s_arready;
        ar_hs         = s_arvalid & s_arready;
        if (ar_hs) r_next = R_DATA;
      end
      R_DATA: begin
        m_rvalid[gr] = s_rvalid;
        s_rready     = m_rready[gr];
        r_hs         = s_rvalid & m_rready[gr];
        if (r_hs) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      gw      <= '0;
      gr      <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (w_state == W_IDLE && w_any) gw <= gw_arb;
      if (r_state == R_IDLE && r_any) gr <= gr_arb;
      if (w_state == W_ADDR && w_next == W_RESP) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        aw_done <= aw_done | aw_hs;
        w_done  <= w_done | w_hs;
      end
    end
  end

endmodule

// File: tb/tb_axil_nto1_interconnect.sv
// Directed self-checking bench for axil_nto1_interconnect (NUM_M=4, 32-bit);
// expectations follow AXIL_NTO1_FIXED_PRIO_EN when it is defined.
module tb_axil_nto1_interconnect;

  localparam int NUM_M  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic                    aclk = 1'b0;
  logic                    areset;
  logic [NUM_M*ADDR_W-1:0] m_awaddr, m_araddr;
  logic [NUM_M*3-1:0]      m_awprot, m_arprot;
  logic [NUM_M-1:0]        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [NUM_M*DATA_W-1:0] m_wdata;
  logic [NUM_M*STRB_W-1:0] m_wstrb;
  logic [1:0]              m_bresp, m_rresp;
  logic [NUM_M-1:0]        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [DATA_W-1:0]       m_rdata;
  logic [ADDR_W-1:0]       s_awaddr, s_araddr;
  logic [2:0]              s_awprot, s_arprot;
  logic                    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic                    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [DATA_W-1:0]       s_wdata, s_rdata;
  logic [STRB_W-1:0]       s_wstrb;
  logic [1:0]              s_bresp, s_rresp;

  int n_pass  = 0;
  int n_total = 0;

  always #5 aclk = ~aclk;

  axil_nto1_interconnect #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .aclk(aclk), .areset(areset),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  task automatic clear_inputs();
    m_awaddr = '0; m_awprot = '0; m_awvalid = '0;
    m_wdata = '0; m_wstrb = '0; m_wvalid = '0; m_bready = '0;
    m_araddr = '0; m_arprot = '0; m_arvalid = '0; m_rready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    clear_inputs();
    m_awvalid = 4'hF; m_wvalid = 4'hF; m_arvalid = 4'hF;
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    n_total++; if (s_awvalid !== 1'b0) $display("FAIL rst_s_awvalid: got %b want 0", s_awvalid); else n_pass++;
    n_total++; if (s_arvalid !== 1'b0) $display("FAIL rst_s_arvalid: got %b want 0", s_arvalid); else n_pass++;
    n_total++; if (m_awready !== 4'h0) $display("FAIL rst_m_awready: got %b want 0000", m_awready); else n_pass++;
    n_total++; if (m_arready !== 4'h0) $display("FAIL rst_m_arready: got %b want 0000", m_arready); else n_pass++;
    clear_inputs();
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    #1;
    n_total++; if (s_wvalid !== 1'b0) $display("FAIL idle_s_wvalid: got %b want 0", s_wvalid); else n_pass++;
    n_total++; if (m_wready !== 4'h0) $display("FAIL idle_m_wready: got %b want 0000", m_wready); else n_pass++;
    n_total++; if (m_bvalid !== 4'h0) $display("FAIL idle_m_bvalid: got %b want 0000", m_bvalid); else n_pass++;
    n_total++; if (m_rvalid !== 4'h0) $display("FAIL idle_m_rvalid: got %b want 0000", m_rvalid); else n_pass++;
    n_total++; if (s_bready !== 1'b0) $display("FAIL idle_s_bready: got %b want 0", s_bready); else n_pass++;
    n_total++; if (s_rready !== 1'b0) $display("FAIL idle_s_rready: got %b want 0", s_rready); else n_pass++;
    n_total++; if (s_awaddr !== 32'h0) $display("FAIL idle_s_awaddr: got %h want 0", s_awaddr); else n_pass++;
    n_total++; if (s_wdata !== 32'h0) $display("FAIL idle_s_wdata: got %h want 0", s_wdata); else n_pass++;
  endtask

  task automatic test_write_m2();
    @(negedge aclk);
    m_awaddr[2*ADDR_W +: ADDR_W] = 32'h0000_0010;
    m_wdata[2*DATA_W +: DATA_W]  = 32'hDEAD_BEEF;
    m_wstrb[2*STRB_W +: STRB_W]  = 4'hF;
    m_awvalid = 4'b0100; m_wvalid = 4'b0100;
    s_awready = 1'b1; s_wready = 1'b1;
    #1;
    n_total++; if (s_awvalid !== 1'b0) $display("FAIL wr2_same_cycle_awvalid: got %b want 0", s_awvalid); else n_pass++;
    @(negedge aclk); #1;
    n_total++; if (s_awaddr !== 32'h10) $display("FAIL wr2_s_awaddr: got %h want 00000010", s_awaddr); else n_pass++;
    n_total++; if (s_wdata !== 32'hDEADBEEF) $display("FAIL wr2_s_wdata: got %h want deadbeef", s_wdata); else n_pass++;
    n_total++; if (s_wstrb !== 4'hF) $display("FAIL wr2_s_wstrb: got %h want f", s_wstrb); else n_pass++;
    n_total++; if (s_awvalid !== 1'b1 || s_wvalid !== 1'b1) $display("FAIL wr2_s_valids: got aw=%b w=%b want 1 1", s_awvalid, s_wvalid); else n_pass++;
    n_total++; if (m_awready !== 4'b0100) $display("FAIL wr2_m_awready: got %b want 0100", m_awready); else n_pass++;
    n_total++; if (m_wready !== 4'b0100) $display("FAIL wr2_m_wready: got %b want 0100", m_wready); else n_pass++;
    @(negedge aclk);
    m_awvalid = '0; m_wvalid = '0;
    s_bvalid = 1'b1; s_bresp = 2'b00; m_bready = 4'b0100;
    #1;
    n_total++; if (m_bvalid !== 4'b0100) $display("FAIL wr2_m_bvalid: got %b want 0100", m_bvalid); else n_pass++;
    n_total++; if (m_bresp !== 2'b00) $display("FAIL wr2_m_bresp: got %b want 00", m_bresp); else n_pass++;
    n_total++; if (s_bready !== 1'b1) $display("FAIL wr2_s_bready: got %b want 1", s_bready); else n_pass++;
    @(negedge aclk);
    s_bvalid = 1'b0; m_bready = '0;
    #1;
    n_total++; if (m_bvalid !== 4'b0000) $display("FAIL wr2_bvalid_after: got %b want 0000", m_bvalid); else n_pass++;
  endtask

  task automatic test_rr_read();
    int          exp_m [5];
    logic [3:0]  exp_oh;
    int          t;
`ifdef AXIL_NTO1_FIXED_PRIO_EN
    exp_m = '{0, 0, 0, 0, 0};
`else
    exp_m = '{0, 1, 2, 3, 0};
`endif
    @(negedge aclk);
    clear_inputs();
    for (int i = 0; i < NUM_M; i++) m_araddr[i*ADDR_W +: ADDR_W] = 32'h100 + 32'(i * 4);
    m_arvalid = 4'hF; m_rready = 4'hF; s_arready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << exp_m[k];
      t = 0;
      do begin
        @(negedge aclk); #1; t++;
      end while (s_arvalid !== 1'b1 && t < 10);
      n_total++; if (s_arvalid !== 1'b1) $display("FAIL rr_timeout_%0d: got s_arvalid=%b want 1", k, s_arvalid); else n_pass++;
      n_total++; if (s_araddr !== 32'h100 + 32'(exp_m[k] * 4)) $display("FAIL rr_grant_%0d: got addr %h want %h", k, s_araddr, 32'h100 + 32'(exp_m[k] * 4)); else n_pass++;
      n_total++; if (m_arready !== exp_oh) $display("FAIL rr_arready_%0d: got %b want %b", k, m_arready, exp_oh); else n_pass++;
      @(negedge aclk);
      s_rvalid = 1'b1; s_rdata = 32'h1000 + 32'(k);
      #1;
      n_total++; if (m_rvalid !== exp_oh) $display("FAIL rr_rvalid_%0d: got %b want %b", k, m_rvalid, exp_oh); else n_pass++;
      n_total++; if (m_rdata !== 32'h1000 + 32'(k)) $display("FAIL rr_rdata_%0d: got %h want %h", k, m_rdata, 32'h1000 + 32'(k)); else n_pass++;
      @(negedge aclk);
      s_rvalid = 1'b0;
      if (k == 4) m_arvalid = '0;
    end
  endtask

  task automatic test_concurrent();
    @(negedge aclk);
    clear_inputs();
    m_awaddr[1*ADDR_W +: ADDR_W] = 32'h20;
    m_wdata[1*DATA_W +: DATA_W]  = 32'h1234_5678;
    m_wstrb[1*STRB_W +: STRB_W]  = 4'h3;
    m_araddr[3*ADDR_W +: ADDR_W] = 32'h30;
    m_awvalid = 4'b0010; m_wvalid = 4'b0010; m_arvalid = 4'b1000;
    m_bready = 4'b0010; m_rready = 4'b1000;
    s_awready = 1'b1; s_wready = 1'b0; s_arready = 1'b1;
    @(negedge aclk); #1;
    n_total++; if (s_awaddr !== 32'h20 || s_awvalid !== 1'b1) $display("FAIL cc_aw: got addr %h valid %b want 00000020 1", s_awaddr, s_awvalid); else n_pass++;
    n_total++; if (s_wdata !== 32'h12345678 || s_wstrb !== 4'h3) $display("FAIL cc_w: got %h/%h want 12345678/3", s_wdata, s_wstrb); else n_pass++;
    n_total++; if (m_awready !== 4'b0010 || m_wready !== 4'b0000) $display("FAIL cc_readies: got aw=%b w=%b want 0010 0000", m_awready, m_wready); else n_pass++;
    n_total++; if (s_araddr !== 32'h30 || m_arready !== 4'b1000) $display("FAIL cc_ar: got %h %b want 00000030 1000", s_araddr, m_arready); else n_pass++;
    @(negedge aclk);
    m_awvalid = '0; m_arvalid = '0;
    s_rvalid = 1'b1; s_rdata = 32'hCAFE_F00D;
    #1;
    n_total++; if (s_awvalid !== 1'b0 || s_wvalid !== 1'b1) $display("FAIL cc_aw_done: got aw=%b w=%b want 0 1", s_awvalid, s_wvalid); else n_pass++;
    n_total++; if (m_rvalid !== 4'b1000 || s_rready !== 1'b1) $display("FAIL cc_rvalid: got %b rready %b want 1000 1", m_rvalid, s_rready); else n_pass++;
    n_total++; if (m_rdata !== 32'hCAFEF00D) $display("FAIL cc_rdata: got %h want cafef00d", m_rdata); else n_pass++;
    @(negedge aclk);
    s_rvalid = 1'b0;
    #1;
    n_total++; if (m_rvalid !== 4'b0000) $display("FAIL cc_rvalid_done: got %b want 0000", m_rvalid); else n_pass++;
    n_total++; if (s_wvalid !== 1'b1 || m_bvalid !== 4'b0000) $display("FAIL cc_w_hold: got w=%b b=%b want 1 0000", s_wvalid, m_bvalid); else n_pass++;
    @(negedge aclk);
    s_wready = 1'b1;
    #1;
    n_total++; if (m_wready !== 4'b0010) $display("FAIL cc_wready: got %b want 0010", m_wready); else n_pass++;
    @(negedge aclk);
    m_wvalid = '0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b10;
    #1;
    n_total++; if (m_bvalid !== 4'b0010 || s_bready !== 1'b1) $display("FAIL cc_bvalid: got %b bready %b want 0010 1", m_bvalid, s_bready); else n_pass++;
    n_total++; if (m_bresp !== 2'b10) $display("FAIL cc_bresp: got %b want 10", m_bresp); else n_pass++;
    @(negedge aclk);
    s_bvalid = 1'b0;
    #1;
    n_total++; if (m_bvalid !== 4'b0000) $display("FAIL cc_b_done: got %b want 0000", m_bvalid); else n_pass++;
  endtask

  task automatic test_rready_stall();
    @(negedge aclk);
    clear_inputs();
    m_araddr[0 +: ADDR_W] = 32'h40;
    m_arvalid = 4'b0001; s_arready = 1'b1;
    @(negedge aclk); #1;
    n_total++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h40) $display("FAIL st_ar: got %b %h want 1 00000040", s_arvalid, s_araddr); else n_pass++;
    @(negedge aclk);
    m_arvalid = '0; m_rready = '0;
    s_rvalid = 1'b1; s_rdata = 32'hA5A5_A5A5;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++; if (m_rvalid !== 4'b0001) $display("FAIL st_rvalid_%0d: got %b want 0001", i, m_rvalid); else n_pass++;
      n_total++; if (s_rready !== 1'b0) $display("FAIL st_rready_%0d: got %b want 0", i, s_rready); else n_pass++;
      n_total++; if (m_rdata !== 32'hA5A5A5A5) $display("FAIL st_rdata_%0d: got %h want a5a5a5a5", i, m_rdata); else n_pass++;
      @(negedge aclk);
    end
    m_rready = 4'b0001;
    #1;
    n_total++; if (s_rready !== 1'b1) $display("FAIL st_rready_rise: got %b want 1", s_rready); else n_pass++;
    @(negedge aclk);
    s_rvalid = 1'b0;
    #1;
    n_total++; if (m_rvalid !== 4'b0000 || s_arvalid !== 1'b0) $display("FAIL st_done: got rvalid %b arvalid %b want 0000 0", m_rvalid, s_arvalid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge aclk);
    clear_inputs();
    m_awaddr[3*ADDR_W +: ADDR_W] = 32'h50;
    m_awaddr[0 +: ADDR_W]        = 32'h60;
    m_awvalid = 4'b1000; m_wvalid = 4'b1000;
    s_awready = 1'b1; s_wready = 1'b1;
    @(negedge aclk); #1;
    n_total++; if (s_awaddr !== 32'h50) $display("FAIL rm_m3_addr: got %h want 00000050", s_awaddr); else n_pass++;
    @(negedge aclk);
    m_awvalid = '0; m_wvalid = '0; m_bready = 4'b1000;
    #1;
    n_total++; if (s_bready !== 1'b1) $display("FAIL rm_in_resp: got s_bready %b want 1", s_bready); else n_pass++;
    areset = 1'b1;
    @(negedge aclk); #1;
    n_total++; if (s_bready !== 1'b0) $display("FAIL rm_bready_drop: got %b want 0", s_bready); else n_pass++;
    n_total++; if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0) $display("FAIL rm_valids_drop: got aw=%b w=%b want 0 0", s_awvalid, s_wvalid); else n_pass++;
    areset = 1'b0;
    m_awvalid = 4'b1001; m_wvalid = 4'b1001;
    @(negedge aclk); #1;
    n_total++; if (s_awaddr !== 32'h60) $display("FAIL rm_ptr_reset_addr: got %h want 00000060", s_awaddr); else n_pass++;
    n_total++; if (m_awready !== 4'b0001) $display("FAIL rm_ptr_reset_ready: got %b want 0001", m_awready); else n_pass++;
    @(negedge aclk);
    m_awvalid = '0; m_wvalid = '0; m_bready = 4'hF; s_bvalid = 1'b1;
    #1;
    n_total++; if (m_bvalid !== 4'b0001) $display("FAIL rm_bvalid: got %b want 0001", m_bvalid); else n_pass++;
    @(negedge aclk);
    s_bvalid = 1'b0;
    #1;
    n_total++; if (m_bvalid !== 4'b0000) $display("FAIL rm_b_done: got %b want 0000", m_bvalid); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_m2();
    test_rr_read();
    test_concurrent();
    test_rready_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
